// File: rtl/riscv_pkg.sv
// Shared types and constants for the instruction fetch front end.
// fetch_entry_t : one buffered instruction word together with its PC.
// fetch_state_e : fetch control states.
// NOP_INSTR     : value presented on the instruction bus while nothing is valid.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    FLUSH
  } fetch_state_e;

  // Sequential fetch address; 32-bit wrap falls out of the modular add.
  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction
endpackage

// File: rtl/if_fetch_unit_if.sv
// Bus bundle of the fetch unit: imem request/response, EX redirect, ID handshake.
// modport master : fetch unit side (drives requests and the ID stream).
// modport slave  : environment side (imem, EX, ID).
interface if_fetch_unit_if;
  import riscv_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_instr;
  logic [XLEN-1:0] id_pc;

  modport master (
    output imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/if_fetch_unit_fifo.sv
// fetch_fifo: small synchronous FIFO with push/pop/flush.
// Ports: clk, rst (sync, active-high, clears pointers/count only),
//        push/wdata, pop/rdata (head, valid when !empty), flush (drops everything,
//        overrides same-cycle push/pop), full, empty, count.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_en, pop_en;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    push_en  = push && !full && !flush;
    pop_en   = pop && !empty && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_en)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push_en) - CW'(pop_en);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is data only: no reset.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= wdata;
  end
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction fetch front end.
// Holds the PC, issues in-order imem requests, buffers returned words with their
// PC and hands {instr, pc} to ID over valid/ready. EX redirects flush everything
// and in-flight responses are counted down and discarded in FLUSH.
// Ports: clk, rst (sync, active-high), bus (if_fetch_unit_if.master).
// Optional: define FETCH_PERF_CNT_EN to add perf_fetched (ID pops) and
// perf_stall (cycles id_valid && !id_ready), both free-running 32-bit counters.
module if_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  if_fetch_unit_if.master  bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]      perf_fetched,
  output logic [31:0]      perf_stall
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   drop_q, drop_d;

  logic            pcq_full, pcq_empty, ibuf_full, ibuf_empty;
  logic [CW-1:0]   pcq_count, ibuf_count;
  logic [XLEN-1:0] pcq_head;
  fetch_entry_t    ibuf_head, ibuf_wdata;
  logic [CW:0]     in_use;
  logic            room, redirect, req_valid, req_fire, rsp_take, id_valid, id_fire;

  always_comb begin
    redirect   = bus.redirect_valid;
    // Outstanding plus buffered must stay below depth so every response has a slot.
    in_use     = {1'b0, pcq_count} + {1'b0, ibuf_count};
    room       = (in_use < (CW+1)'(FIFO_DEPTH)) && !pcq_full;
    req_valid  = (state_q == FETCH) && room && !redirect;
    req_fire   = req_valid && bus.imem_req_ready;
    rsp_take   = bus.imem_rsp_valid && (state_q == FETCH) && !pcq_empty && !ibuf_full;
    id_valid   = !ibuf_empty;
    id_fire    = id_valid && bus.id_ready;
    ibuf_wdata = '{instr: bus.imem_rsp_data, pc: pcq_head};
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(XLEN), .CW(CW)) u_pc_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (req_fire),
    .wdata (fetch_pc_q),
    .pop   (rsp_take),
    .flush (redirect),
    .rdata (pcq_head),
    .full  (pcq_full),
    .empty (pcq_empty),
    .count (pcq_count)
  );

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(fetch_entry_t)), .CW(CW)) u_instr_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (rsp_take),
    .wdata (ibuf_wdata),
    .pop   (id_fire),
    .flush (redirect),
    .rdata (ibuf_head),
    .full  (ibuf_full),
    .empty (ibuf_empty),
    .count (ibuf_count)
  );

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    unique case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: state_d = FETCH;
      FLUSH: begin
        if (bus.imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - CW'(1);
        if (drop_d == '0) state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
    if (req_fire) fetch_pc_d = next_pc(fetch_pc_q);
    if (redirect) begin
      fetch_pc_d = bus.redirect_pc;
      // A response landing this cycle is already gone; only the rest must be dropped.
      if (state_q == FETCH) drop_d = pcq_count - CW'(rsp_take);
      state_d = (drop_d != '0) ? FLUSH : FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      drop_q     <= drop_d;
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.id_valid       = id_valid;
  assign bus.id_instr       = id_valid ? ibuf_head.instr : NOP_INSTR;
  assign bus.id_pc          = ibuf_head.pc;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d, perf_stall_q, perf_stall_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q + 32'(id_fire);
    perf_stall_d   = perf_stall_q + 32'(id_valid && !bus.id_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// Testbench for if_fetch_unit: randomized imem/ID/redirect traffic against a
// program-order reference model (expected fetch address and expected ID PC
// streams, plus an in-order memory responder whose data is a function of address).
module tb_if_fetch_unit;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          FIFO_DEPTH = 2;

  logic clk;
  logic rst;
  if_fetch_unit_if bus_if();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_stall;
`endif

  if_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_stall   (perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          cyc;
  } inflight_t;

  inflight_t   imem_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          pops     = 0;
  logic [31:0] exp_fetch, exp_id_pc;
  int unsigned m_fetched, m_stall;
  bit          prev_req_stall, prev_redir, prev_id_stall;
  logic [31:0] prev_instr, prev_pc;
  int          p_rr, p_rsp, p_idr, p_redir;
  bit          force_tgt_en;
  logic [31:0] force_tgt;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_3C3C;
  endfunction

  function automatic bit pct(input int p);
    return $urandom_range(0, 99) < p;
  endfunction

  task automatic idle_inputs();
    bus_if.imem_req_ready = 1'b0;
    bus_if.imem_rsp_valid = 1'b0;
    bus_if.imem_rsp_data  = '0;
    bus_if.redirect_valid = 1'b0;
    bus_if.redirect_pc    = '0;
    bus_if.id_ready       = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    imem_q.delete();
    exp_fetch = RESET_PC;
    exp_id_pc = RESET_PC;
    m_fetched = 0;
    m_stall = 0;
    prev_req_stall = 0;
    prev_redir = 0;
    prev_id_stall = 0;
    @(negedge clk);
    #1;
    check_val("rst_req_valid", 32'(bus_if.imem_req_valid), 32'd0);
    check_val("rst_id_valid", 32'(bus_if.id_valid), 32'd0);
`ifdef FETCH_PERF_CNT_EN
    check_val("rst_perf_fetched", perf_fetched, 32'd0);
    check_val("rst_perf_stall", perf_stall, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step();
    logic [31:0] tgt;
    bit req_fire, id_fire, rsp, redir;
    @(negedge clk);
    cyc++;
    tgt = force_tgt_en ? force_tgt : ($urandom() & 32'hFFFF_FFFC);
    bus_if.imem_req_ready = pct(p_rr);
    bus_if.id_ready       = pct(p_idr);
    bus_if.redirect_valid = pct(p_redir);
    bus_if.redirect_pc    = tgt;
    rsp = (imem_q.size() > 0) && (imem_q[0].cyc < cyc) && pct(p_rsp);
    bus_if.imem_rsp_valid = rsp;
    bus_if.imem_rsp_data  = rsp ? mem_word(imem_q[0].addr) : $urandom();
    #1;
    redir = bus_if.redirect_valid;
    if (redir) check_val("req_gated_on_redirect", 32'(bus_if.imem_req_valid), 32'd0);
    else if (prev_req_stall) check_val("req_held", 32'(bus_if.imem_req_valid), 32'd1);
    if (bus_if.imem_req_valid) check_val("req_addr", bus_if.imem_req_addr, exp_fetch);
    if (prev_redir) check_val("id_killed", 32'(bus_if.id_valid), 32'd0);
    else if (prev_id_stall) begin
      check_val("id_held", 32'(bus_if.id_valid), 32'd1);
      check_val("id_instr_held", bus_if.id_instr, prev_instr);
      check_val("id_pc_held", bus_if.id_pc, prev_pc);
    end
    req_fire = bus_if.imem_req_valid && bus_if.imem_req_ready;
    id_fire  = bus_if.id_valid && bus_if.id_ready;
    if (id_fire) begin
      check_val("id_pc", bus_if.id_pc, exp_id_pc);
      check_val("id_instr", bus_if.id_instr, mem_word(exp_id_pc));
      pops++;
    end
    // Advance the reference model across the coming rising edge.
    if (id_fire) begin
      exp_id_pc += 32'd4;
      m_fetched++;
    end
    if (bus_if.id_valid && !bus_if.id_ready) m_stall++;
    if (rsp) void'(imem_q.pop_front());
    if (req_fire) begin
      imem_q.push_back('{addr: exp_fetch, cyc: cyc});
      exp_fetch += 32'd4;
      check_val("inflight_bound", 32'(imem_q.size() <= FIFO_DEPTH), 32'd1);
    end
    if (redir) begin
      exp_fetch = tgt;
      exp_id_pc = tgt;
    end
    prev_req_stall = bus_if.imem_req_valid && !bus_if.imem_req_ready;
    prev_redir     = redir;
    prev_id_stall  = bus_if.id_valid && !bus_if.id_ready;
    prev_instr     = bus_if.id_instr;
    prev_pc        = bus_if.id_pc;
  endtask

  task automatic run(input int n, input int rr, input int rs, input int idr, input int rd);
    p_rr = rr;
    p_rsp = rs;
    p_idr = idr;
    p_redir = rd;
    for (int i = 0; i < n; i++) step();
    force_tgt_en = 0;
  endtask

  task automatic redirect_to(input logic [31:0] tgt, input int rr, input int rs, input int idr);
    force_tgt_en = 1;
    force_tgt = tgt;
    run(1, rr, rs, idr, 100);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    force_tgt_en = 0;
    force_tgt = '0;
    do_reset();
    // Straight-line fetch, everything ready.
    run(30, 100, 100, 100, 0);
    // ID stall, then resume.
    run(12, 100, 100, 0, 0);
    run(20, 100, 100, 100, 0);
    // imem refuses requests.
    run(6, 0, 100, 100, 0);
    run(10, 100, 100, 100, 0);
    // Build outstanding requests, then redirect with them in flight.
    run(3, 100, 0, 0, 0);
    redirect_to(32'h0000_0100, 100, 0, 100);
    run(25, 100, 100, 100, 0);
    // Redirect together with an ID pop and an imem response.
    run(4, 100, 100, 100, 0);
    redirect_to(32'h0000_0200, 100, 100, 100);
    run(25, 100, 100, 100, 0);
    // Address wrap at the top of the space.
    redirect_to(32'hFFFF_FFF8, 100, 100, 100);
    run(25, 100, 100, 100, 0);
    // Random traffic.
    run(1500, 70, 50, 60, 3);
    // Reset in the middle of traffic.
    run(7, 70, 50, 60, 3);
    do_reset();
    run(400, 80, 60, 70, 2);
    check_val("progress", 32'(pops >= 200), 32'd1);
`ifdef FETCH_PERF_CNT_EN
    #1;
    check_val("perf_fetched", perf_fetched, m_fetched);
    check_val("perf_stall", perf_stall, m_stall);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
